// File: rtl/alarm_pkg.sv
// Shared time width, channel state encoding and BCD time helpers for the
// multi-channel alarm clock.
package alarm_pkg;

   localparam int TIME_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } alarm_state_t;

   // HH <= 23, MM <= 59, every nibble a decimal digit
   function automatic logic bcd_valid(input logic [TIME_W-1:0] t);
      return (t[15:8] <= 8'h23) && (t[11:8] <= 4'd9) &&
             (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
   endfunction

   function automatic logic [TIME_W-1:0] bcd_inc(input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0] r;
      r = t;
      if (t == 16'h2359) begin
         r = 16'h0000;
      end else if (t[7:0] == 8'h59) begin
         r[7:0] = 8'h00;
         if (t[11:8] == 4'd9) begin
            r[15:12] = t[15:12] + 4'd1;
            r[11:8]  = 4'd0;
         end else begin
            r[11:8] = t[11:8] + 4'd1;
         end
      end else if (t[3:0] == 4'd9) begin
         r[7:4] = t[7:4] + 4'd1;
         r[3:0] = 4'd0;
      end else begin
         r[3:0] = t[3:0] + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time/enable, ring/snooze FSM and a
// minute down-counter that times both the snooze and the ring window.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_IDLE    | armed (if enabled), waiting for a minute-update match
//   ST_RINGING | alarm sounding; min_cnt counts down to auto-stop
//   ST_SNOOZED | silenced; min_cnt counts down to re-ring
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN   = 9,
   parameter int RING_MAX_MIN = 5
) (
   input  logic              clk256,
   input  logic              reset,
   input  logic              load,
   input  logic [TIME_W-1:0] alarm_in,
   input  logic              en_in,
   input  logic [TIME_W-1:0] time_now,
   input  logic              time_upd,
   input  logic              min_tick,
   input  logic              snooze,
   input  logic              stop_alarm,
   output logic [TIME_W-1:0] alarm_time,
   output logic              ringing
);

   alarm_state_t state, state_nxt;
   logic [5:0]   min_cnt, min_cnt_nxt;
   logic         alarm_en;

   always_ff @(posedge clk256) begin
      if (reset) begin
         state      <= ST_IDLE;
         min_cnt    <= 6'd0;
         alarm_time <= '0;
         alarm_en   <= 1'b0;
      end else begin
         state   <= state_nxt;
         min_cnt <= min_cnt_nxt;
         if (load) begin
            alarm_time <= alarm_in;
            alarm_en   <= en_in;
         end
      end
   end

   // Priority: load, then stop, then snooze, then minute timeout.
   always_comb begin
      state_nxt   = state;
      min_cnt_nxt = min_cnt;
      if (load) begin
         state_nxt   = ST_IDLE;
         min_cnt_nxt = 6'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (alarm_en && time_upd && (time_now == alarm_time)) begin
                  state_nxt   = ST_RINGING;
                  min_cnt_nxt = 6'(RING_MAX_MIN);
               end
            end
            ST_RINGING: begin
               if (stop_alarm) begin
                  state_nxt   = ST_IDLE;
                  min_cnt_nxt = 6'd0;
               end else if (snooze) begin
                  state_nxt   = ST_SNOOZED;
                  min_cnt_nxt = 6'(SNOOZE_MIN);
               end else if (min_tick) begin
                  if (min_cnt == 6'd1) begin
                     state_nxt   = ST_IDLE;
                     min_cnt_nxt = 6'd0;
                  end else begin
                     min_cnt_nxt = min_cnt - 6'd1;
                  end
               end
            end
            ST_SNOOZED: begin
               if (stop_alarm) begin
                  state_nxt   = ST_IDLE;
                  min_cnt_nxt = 6'd0;
               end else if (min_tick) begin
                  if (min_cnt == 6'd1) begin
                     state_nxt   = ST_RINGING;
                     min_cnt_nxt = 6'(RING_MAX_MIN);
                  end else begin
                     min_cnt_nxt = min_cnt - 6'd1;
                  end
               end
            end
            default: begin
               state_nxt   = ST_IDLE;
               min_cnt_nxt = 6'd0;
            end
         endcase
      end
   end

   assign ringing = (state == ST_RINGING);

endmodule

// File: rtl/multi_alarm_core.sv
// BCD HH:MM timekeeper with NUM_ALARMS independent alarm channels and a
// registered display mux.
module multi_alarm_core
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS    = 4,
   parameter int TICKS_PER_SEC = 256,
   parameter int SNOOZE_MIN    = 9,
   parameter int RING_MAX_MIN  = 5,
   localparam int SEL_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk256,
   input  logic                  reset,
   input  logic                  fast_mode,
   input  logic                  load_time,
   input  logic [TIME_W-1:0]     time_in,
   input  logic                  load_alarm,
   input  logic [SEL_W-1:0]      alarm_sel,
   input  logic [TIME_W-1:0]     alarm_in,
   input  logic                  alarm_en_in,
   input  logic                  snooze,
   input  logic                  stop_alarm,
   input  logic                  show_alarm,
   input  logic [SEL_W-1:0]      show_sel,
   output logic [TIME_W-1:0]     current_time,
   output logic [TIME_W-1:0]     display,
   output logic                  one_minute,
   output logic [NUM_ALARMS-1:0] ringing,
   output logic                  sound_alarm
);

   localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic [5:0]        sec_cnt;
   logic              one_second;
   logic              min_tick;
   logic              time_load_ok;
   logic              alarm_load_ok;
   logic              time_upd;
   logic [TIME_W-1:0] display_nxt;
   logic [TIME_W-1:0] alarm_time [NUM_ALARMS];

   assign one_second    = (tick_cnt == TICK_MAX);
   assign min_tick      = one_second && (fast_mode || (sec_cnt == 6'd59));
   assign time_load_ok  = load_time && bcd_valid(time_in);
   assign alarm_load_ok = load_alarm && bcd_valid(alarm_in);
   assign one_minute    = min_tick;

   always_ff @(posedge clk256) begin
      if (reset) begin
         tick_cnt     <= '0;
         sec_cnt      <= 6'd0;
         current_time <= '0;
         time_upd     <= 1'b0;
      end else begin
         if (time_load_ok) begin
            current_time <= time_in;
            tick_cnt     <= '0;
            sec_cnt      <= 6'd0;
         end else begin
            tick_cnt <= one_second ? '0 : tick_cnt + TICK_W'(1);
            if (min_tick) begin
               sec_cnt      <= 6'd0;
               current_time <= bcd_inc(current_time);
            end else if (one_second) begin
               sec_cnt <= sec_cnt + 6'd1;
            end
         end
         // Channels compare against the freshly incremented time only;
         // a time load never counts as a match opportunity.
         time_upd <= min_tick && !time_load_ok;
      end
   end

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
      alarm_channel #(
         .SNOOZE_MIN   (SNOOZE_MIN),
         .RING_MAX_MIN (RING_MAX_MIN)
      ) u_ch (
         .clk256     (clk256),
         .reset      (reset),
         .load       (alarm_load_ok && (4'(alarm_sel) == 4'(i))),
         .alarm_in   (alarm_in),
         .en_in      (alarm_en_in),
         .time_now   (current_time),
         .time_upd   (time_upd),
         .min_tick   (min_tick),
         .snooze     (snooze),
         .stop_alarm (stop_alarm),
         .alarm_time (alarm_time[i]),
         .ringing    (ringing[i])
      );
   end

   assign sound_alarm = |ringing;

   always_comb begin
      display_nxt = current_time;
      if (show_alarm) begin
         display_nxt = '0;
         if (4'(show_sel) < 4'(NUM_ALARMS)) display_nxt = alarm_time[show_sel];
      end
   end

   always_ff @(posedge clk256) begin
      if (reset) display <= '0;
      else       display <= display_nxt;
   end

endmodule

// File: tb/tb_multi_alarm_core.sv
// Directed bench for multi_alarm_core: timekeeping wrap, ring/snooze/stop,
// auto-stop, invalid loads, display mux and reset mid-ring.
module tb_multi_alarm_core;

   logic        clk256 = 1'b0;
   logic        reset;
   logic        fast_mode;
   logic        load_time;
   logic [15:0] time_in;
   logic        load_alarm;
   logic [1:0]  alarm_sel;
   logic [15:0] alarm_in;
   logic        alarm_en_in;
   logic        snooze;
   logic        stop_alarm;
   logic        show_alarm;
   logic [1:0]  show_sel;
   logic [15:0] current_time;
   logic [15:0] display;
   logic        one_minute;
   logic [3:0]  ringing;
   logic        sound_alarm;

   int tests = 0;
   int fails = 0;
   int om_cnt = 0;

   multi_alarm_core dut (
      .clk256       (clk256),
      .reset        (reset),
      .fast_mode    (fast_mode),
      .load_time    (load_time),
      .time_in      (time_in),
      .load_alarm   (load_alarm),
      .alarm_sel    (alarm_sel),
      .alarm_in     (alarm_in),
      .alarm_en_in  (alarm_en_in),
      .snooze       (snooze),
      .stop_alarm   (stop_alarm),
      .show_alarm   (show_alarm),
      .show_sel     (show_sel),
      .current_time (current_time),
      .display      (display),
      .one_minute   (one_minute),
      .ringing      (ringing),
      .sound_alarm  (sound_alarm)
   );

   always #5 clk256 = ~clk256;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk256);
         if (one_minute) om_cnt++;
      end
   endtask

   task automatic set_time(input logic [15:0] t);
      time_in   = t;
      load_time = 1'b1;
      @(negedge clk256);
      load_time = 1'b0;
   endtask

   task automatic set_alarm(input logic [1:0] sel, input logic [15:0] t, input logic en);
      alarm_sel   = sel;
      alarm_in    = t;
      alarm_en_in = en;
      load_alarm  = 1'b1;
      @(negedge clk256);
      load_alarm  = 1'b0;
   endtask

   task automatic pulse_snooze_stop(input logic sn, input logic st);
      snooze     = sn;
      stop_alarm = st;
      @(negedge clk256);
      snooze     = 1'b0;
      stop_alarm = 1'b0;
   endtask

   // Bounded wait; a timeout shows up as a failed time comparison.
   task automatic wait_time(input logic [15:0] t);
      int n;
      n = 0;
      while (current_time !== t && n < 4000) begin
         @(negedge clk256);
         n++;
      end
      check("wait_time", current_time, t);
   endtask

   initial begin
      reset = 1'b1; fast_mode = 1'b0; load_time = 1'b0; time_in = '0;
      load_alarm = 1'b0; alarm_sel = '0; alarm_in = '0; alarm_en_in = 1'b0;
      snooze = 1'b0; stop_alarm = 1'b0; show_alarm = 1'b0; show_sel = '0;
      repeat (2) @(negedge clk256);
      check("rst_time", current_time, 16'h0000);
      check("rst_display", display, 16'h0000);
      check("rst_one_minute", {15'd0, one_minute}, 16'h0000);
      check("rst_ringing", {12'd0, ringing}, 16'h0000);
      check("rst_sound", {15'd0, sound_alarm}, 16'h0000);
      reset = 1'b0;
      fast_mode = 1'b1;

      // 23:59 wraps to 00:00 after exactly 256 cycles
      set_time(16'h2359);
      check("load_2359", current_time, 16'h2359);
      om_cnt = 0;
      run(255);
      check("pre_wrap_time", current_time, 16'h2359);
      check("pre_wrap_om", 16'(om_cnt), 16'd1);
      run(1);
      check("wrap_time", current_time, 16'h0000);
      check("wrap_om_count", 16'(om_cnt), 16'd1);
      check("wrap_om_low", {15'd0, one_minute}, 16'h0000);

      set_alarm(2'd0, 16'h0700, 1'b1);
      set_alarm(2'd1, 16'h1230, 1'b1);
      set_alarm(2'd2, 16'h1230, 1'b0);

      // Ring one cycle after the matching update
      set_time(16'h0659);
      run(255);
      check("pre_0700_time", current_time, 16'h0659);
      check("pre_0700_ring", {12'd0, ringing}, 16'h0000);
      run(1);
      check("at_0700_time", current_time, 16'h0700);
      check("at_0700_ring", {12'd0, ringing}, 16'h0000);
      run(1);
      check("ring_0700", {12'd0, ringing}, 16'h0001);
      check("sound_0700", {15'd0, sound_alarm}, 16'h0001);

      // Snooze for nine minutes
      pulse_snooze_stop(1'b1, 1'b0);
      check("snoozed", {12'd0, ringing}, 16'h0000);
      wait_time(16'h0708);
      check("snooze_0708", {12'd0, ringing}, 16'h0000);
      wait_time(16'h0709);
      check("rering_0709", {12'd0, ringing}, 16'h0001);
      run(2);
      check("display_time", display, 16'h0709);

      // Snooze together with stop: stop wins, no re-ring
      pulse_snooze_stop(1'b1, 1'b1);
      check("stop_wins", {12'd0, ringing}, 16'h0000);
      wait_time(16'h0718);
      check("no_rering_0718", {12'd0, ringing}, 16'h0000);
      run(2);
      check("no_rering_0718b", {12'd0, ringing}, 16'h0000);

      // Two channels at 12:30, channel 2 disabled; auto-stop after 5 minutes
      set_time(16'h1229);
      wait_time(16'h1230);
      check("at_1230_ring", {12'd0, ringing}, 16'h0000);
      run(1);
      check("ring_1230", {12'd0, ringing}, 16'h0002);
      check("sound_1230", {15'd0, sound_alarm}, 16'h0001);
      wait_time(16'h1234);
      check("ring_1234", {12'd0, ringing}, 16'h0002);
      wait_time(16'h1235);
      check("auto_idle_1235", {12'd0, ringing}, 16'h0000);
      check("sound_off_1235", {15'd0, sound_alarm}, 16'h0000);

      // Invalid time load ignored; display mux
      set_time(16'h2460);
      check("bad_time_ignored", current_time, 16'h1235);
      show_alarm = 1'b1;
      show_sel = 2'd1;
      run(1);
      check("show_alarm1", display, 16'h1230);
      show_sel = 2'd0;
      run(1);
      check("show_alarm0", display, 16'h0700);
      show_sel = 2'd3;
      run(1);
      check("show_alarm3", display, 16'h0000);
      set_alarm(2'd3, 16'h1275, 1'b1);
      run(1);
      check("bad_alarm_ignored", display, 16'h0000);
      set_alarm(2'd3, 16'h1236, 1'b1);
      run(1);
      check("alarm3_loaded", display, 16'h1236);

      // load_alarm in the match cycle keeps the channel idle
      wait_time(16'h1236);
      set_alarm(2'd3, 16'h1236, 1'b1);
      check("load_beats_match", {12'd0, ringing}, 16'h0000);
      run(2);
      check("load_beats_match2", {12'd0, ringing}, 16'h0000);

      // Reset mid-ring
      set_alarm(2'd1, 16'h1237, 1'b1);
      wait_time(16'h1237);
      run(1);
      check("ring_1237", {12'd0, ringing}, 16'h0002);
      reset = 1'b1;
      @(negedge clk256);
      check("midring_rst_ring", {12'd0, ringing}, 16'h0000);
      check("midring_rst_time", current_time, 16'h0000);
      check("midring_rst_disp", display, 16'h0000);
      check("midring_rst_sound", {15'd0, sound_alarm}, 16'h0000);
      reset = 1'b0;
      show_sel = 2'd1;
      run(1);
      check("alarm_cleared", display, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
